// File: rtl/ebi_read_responder.sv
// EBI read responder: synchronizes the MCU external bus and issues one fabric read per RE low pulse.
// It then returns the fabric data, or IDLE_DATA on timeout, to the pad driver while RE stays low.
module ebi_read_responder #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [15:0] IDLE_DATA      = 16'hDEAD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] EBI_AD,
   input  logic        EBI_ALE,
   input  logic        EBI_CS,
   input  logic        EBI_RE,
   input  logic        EBI_WE,
   output logic [15:0] ebi_ad_out,
   output logic        ebi_ad_oe,
   output logic [15:0] rd_addr,
   output logic        rd_req,
   input  logic [15:0] rd_data,
   input  logic        rd_valid,
   output logic        timeout_err
);

   localparam int unsigned AW  = 16;
   localparam int unsigned SS  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned SW  = AW + 4;
   localparam int unsigned TMO = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
   localparam int unsigned CW  = (TMO > 1) ? $clog2(TMO) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRIVE
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   sync_q [SS];
   logic [AW-1:0]   ad_s;
   logic            ale_s, cs_s, re_s, we_s, we_nxt;
   logic            re_prev_q;
   logic [AW-1:0]   addr_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic [AW-1:0]   ad_out_q, ad_out_d;
   logic            rd_req_q, oe_q, terr_q, terr_d;
   logic            abort;
   logic            rd_start;

   // Input synchronizers; bus and strobes share one chain so they stay aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(SS); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= {EBI_AD, EBI_ALE, EBI_CS, EBI_RE, EBI_WE};
         for (int i = 1; i < int'(SS); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign ad_s   = sync_q[SS-1][SW-1:4];
   assign ale_s  = sync_q[SS-1][3];
   assign cs_s   = sync_q[SS-1][2];
   assign re_s   = sync_q[SS-1][1];
   assign we_s   = sync_q[SS-1][0];
   // Value WE_s takes after the coming edge, so the registered enable never overlaps a write.
   assign we_nxt = sync_q[SS-2][0];

   // Address phase latch and RE edge history.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         re_prev_q <= 1'b0;
      end else begin
         re_prev_q <= re_s;
         if (!ale_s) begin
            addr_q <= ad_s;
         end
      end
   end

   assign abort    = re_s | cs_s;
   assign rd_start = !cs_s && we_s && !re_s && re_prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         ad_out_q  <= '0;
         rd_req_q  <= 1'b0;
         oe_q      <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         ad_out_q  <= ad_out_d;
         rd_req_q  <= (state_d == ST_REQ);
         oe_q      <= (state_d == ST_DRIVE) && we_nxt;
         terr_q    <= terr_d;
      end
   end

   // Next-state: one request per RE falling edge, then wait for data, timeout or abort.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_addr_d = rd_addr_q;
      ad_out_d  = ad_out_q;
      terr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rd_start) begin
               state_d   = ST_REQ;
               rd_addr_d = addr_q;
            end
         end
         ST_REQ: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (rd_valid) begin
               state_d  = ST_DRIVE;
               ad_out_d = rd_data;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (rd_valid) begin
               state_d  = ST_DRIVE;
               ad_out_d = rd_data;
            end else if (cnt_q == CW'(TMO - 1)) begin
               state_d  = ST_DRIVE;
               ad_out_d = IDLE_DATA;
               terr_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DRIVE: begin
            if (abort || !we_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ebi_ad_out  = ad_out_q;
   assign ebi_ad_oe   = oe_q;
   assign rd_addr     = rd_addr_q;
   assign rd_req      = rd_req_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_ebi_read_responder.sv
// Bench for ebi_read_responder: scripted bus transactions with random timing, and expected
// waveforms derived from event times (request, data arrival, RE/CS release, reset).
module tb_ebi_read_responder;

   localparam int TMO = 16;
   localparam int K   = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] EBI_AD;
   logic        EBI_ALE, EBI_CS, EBI_RE, EBI_WE;
   logic [15:0] ebi_ad_out;
   logic        ebi_ad_oe;
   logic [15:0] rd_addr;
   logic        rd_req;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        timeout_err;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [15:0] m_addr;
   logic [15:0] m_out;

   always #5 clk = ~clk;

   ebi_read_responder dut (
      .clk         (clk),
      .reset       (reset),
      .EBI_AD      (EBI_AD),
      .EBI_ALE     (EBI_ALE),
      .EBI_CS      (EBI_CS),
      .EBI_RE      (EBI_RE),
      .EBI_WE      (EBI_WE),
      .ebi_ad_out  (ebi_ad_out),
      .ebi_ad_oe   (ebi_ad_oe),
      .rd_addr     (rd_addr),
      .rd_req      (rd_req),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .timeout_err (timeout_err)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   // kind 0 read, 1 write cycle (hc!=0: RE pulses while WE low), 2 RE low with CS high,
   // 3 read with reset at cycle rst_at. lat<0: fabric never answers.
   task automatic run_txn(input int kind, input logic [15:0] addr, input int lat,
                          input int h, input int hc, input int rst_at, input logic [15:0] data);
      int          r, d, e, entry, n, last_act;
      bit          rd, timed, drove, cs_lo, re_lo, we_lo, noise;
      logic [15:0] val, a0, o0, x_addr, x_out;
      rd       = (kind == 0) || (kind == 3);
      r        = K + 2;
      d        = r + ((hc < h) ? hc : h);
      if (rst_at >= 0 && rst_at < d) d = rst_at;
      e        = (lat >= 0) ? r + 1 + lat : (1 << 20);
      timed    = (e > r + 1 + TMO);
      entry    = timed ? r + 1 + TMO : e;
      drove    = rd && (entry < d);
      val      = timed ? 16'hDEAD : data;
      last_act = !rd ? -1 : (drove ? entry : d);
      n        = K + ((h > 24) ? h : 24) + 6;
      a0       = m_addr;
      o0       = m_out;
      for (int j = 0; j < n; j++) begin
         EBI_ALE = !(j == 2 || j == 3);
         EBI_AD  = (j == 2 || j == 3) ? addr : 16'($urandom);
         case (kind)
            1: begin
               cs_lo = (j >= 2) && (j < K + h + 1);
               re_lo = (hc != 0) && (j >= K) && (j < K + h);
               we_lo = (j >= 3) && (j < K + h + 2);
            end
            2: begin
               cs_lo = 1'b0;
               re_lo = (j >= K) && (j < K + h);
               we_lo = 1'b0;
            end
            default: begin
               cs_lo = (j >= 2) && (j < K + hc);
               re_lo = (j >= K) && (j < K + h);
               we_lo = 1'b0;
            end
         endcase
         EBI_CS   = !cs_lo;
         EBI_RE   = !re_lo;
         EBI_WE   = !we_lo;
         reset    = (j == rst_at);
         noise    = ($urandom_range(7) == 0) && (!rd || j <= r || j > last_act);
         rd_valid = (rd && j == e) || noise;
         rd_data  = (rd && j == e) ? data : 16'($urandom);
         @(posedge clk);
         @(negedge clk);
         x_addr = (rst_at >= 0 && j >= rst_at) ? 16'h0000 : ((rd && j >= r) ? addr : a0);
         x_out  = (rst_at >= 0 && j >= rst_at) ? 16'h0000 : ((drove && j >= entry) ? val : o0);
         check("rd_req",      16'(rd_req),      16'(rd && j == r));
         check("rd_addr",     rd_addr,          x_addr);
         check("ebi_ad_oe",   16'(ebi_ad_oe),   16'(drove && j >= entry && j < d));
         check("ebi_ad_out",  ebi_ad_out,       x_out);
         check("timeout_err", 16'(timeout_err), 16'(drove && timed && j == entry));
         m_addr = x_addr;
         m_out  = x_out;
      end
      reset    = 1'b0;
      rd_valid = 1'b0;
   endtask

   initial begin
      int kind, lat, h, hc;
      reset    = 1'b1;
      EBI_AD   = '0;
      EBI_ALE  = 1'b1;
      EBI_CS   = 1'b1;
      EBI_RE   = 1'b1;
      EBI_WE   = 1'b1;
      rd_data  = '0;
      rd_valid = 1'b0;
      m_addr   = '0;
      m_out    = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_rd_req",  16'(rd_req),      16'h0000);
         check("rst_oe",      16'(ebi_ad_oe),   16'h0000);
         check("rst_ad_out",  ebi_ad_out,       16'h0000);
         check("rst_rd_addr", rd_addr,          16'h0000);
         check("rst_terr",    16'(timeout_err), 16'h0000);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
      end

      run_txn(0, 16'h0042, 2,  8,  9,  -1, 16'hBEEF);
      run_txn(0, 16'h0042, 0,  8,  9,  -1, 16'hBEEF);
      run_txn(0, 16'h0100, -1, 22, 23, -1, 16'h1234);
      run_txn(0, 16'h0200, 5,  4,  5,  -1, 16'h5555);
      run_txn(1, 16'h0300, 0,  6,  0,  -1, 16'h0000);
      run_txn(1, 16'h0301, 0,  6,  1,  -1, 16'h0000);
      run_txn(2, 16'h0400, 0,  6,  7,  -1, 16'h4444);
      run_txn(3, 16'h0500, 0,  12, 13, 11, 16'hCAFE);
      run_txn(0, 16'h0007, 1,  6,  7,  -1, 16'h7777);
      run_txn(0, 16'h0808, 16, 24, 25, -1, 16'hA5A5);
      run_txn(0, 16'h0809, 17, 24, 25, -1, 16'h5A5A);
      run_txn(0, 16'h0900, 3,  9,  2,  -1, 16'h9999);

      for (int t = 0; t < 40; t++) begin
         kind = ($urandom_range(9) < 7) ? 0 : int'($urandom_range(1, 2));
         lat  = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(20));
         h    = int'($urandom_range(1, 24));
         hc   = ($urandom_range(3) == 0) ? int'($urandom_range(1, h)) : h + 1;
         if (kind == 1) hc = int'($urandom_range(1));
         run_txn(kind, 16'($urandom), lat, h, hc, -1, 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
